// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding,
// timeout defaults and small address helpers.
package mem_bus_arbiter_pkg;

    // Arbiter FSM states (2-bit encoding, IDLE is the reset state)
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUS_DATA = 2'd1,
        ST_BUS_INST = 2'd2,
        ST_RESP     = 2'd3
    } arb_state_t;

    // Default number of cycles waited for bus_ack before aborting (1..255)
    localparam int TIMEOUT_CYCLES_DEF = 255;

    // Width of the timeout counter; wide enough for the largest timeout
    localparam int TMO_CNT_W = 8;

    // Byte enables used for instruction fetches (always a full word)
    localparam logic [3:0] BE_FULL = 4'b1111;

    // The external bus is word addressed: low two address bits are dropped
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_bus_timeout_counter.sv
// Timeout counter for one outstanding bus cycle. Cleared whenever no bus
// cycle is in flight, counts every waiting cycle, and flags expiry on the
// cycle in which the waited count reaches LIMIT.
module bus_timeout_counter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    // Count value at which the current waiting cycle is the LIMIT-th one
    localparam logic [TMO_CNT_W-1:0] LIMIT_M1 = TMO_CNT_W'(LIMIT - 1);

    logic [TMO_CNT_W-1:0] r_count;

    // Waiting-cycle counter: clear has priority, otherwise count while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + TMO_CNT_W'(1);
        end
    end

    // Expiry is only meaningful while the owner is actually waiting
    assign o_expire = i_enable && (r_count == LIMIT_M1);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter sitting behind the MMU. Serialises the instruction
// fetch port and the data port onto one external bus, returns read data
// with a one-cycle ack pulse per port, stalls the pipeline while a request
// is outstanding and aborts bus cycles that never see bus_ack.
//
// Handshake on both requester ports: x_req rises with stable address/data
// and stays high until the cycle x_ack is high; x_ack is a single-cycle
// pulse, x_rdata is valid in that cycle, and the requester drops x_req on
// the following edge. On the bus side bus_req and all bus_* outputs stay
// stable until bus_ack is seen (or the timeout fires); bus_ack is ignored
// whenever bus_req is low.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction fetch port
    input  logic        inst_req,
    input  logic [31:0] inst_paddr,
    output logic [31:0] inst_rdata,
    output logic        inst_ack,
    // data port
    input  logic        data_req,
    input  logic        data_we,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_paddr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ack,
    // status
    output logic        bus_err,
    output logic        stall,
    // external memory bus
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    // debug view of the arbiter FSM
    output logic [1:0]  o_dbg_state
);

    arb_state_t  r_state;
    logic        r_bus_req;
    logic [31:0] r_bus_addr;
    logic        r_bus_we;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_inst_rdata;
    logic [31:0] r_data_rdata;
    logic        r_inst_ack;
    logic        r_data_ack;
    logic        r_bus_err;

    logic        w_in_bus;
    logic        w_expire;

    assign w_in_bus = (r_state == ST_BUS_DATA) || (r_state == ST_BUS_INST);

    // Counter is held clear outside a bus cycle, so it starts at zero on entry
    bus_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (!w_in_bus),
        .i_enable (w_in_bus && !bus_ack),
        .o_expire (w_expire)
    );

    // Arbiter FSM with all bus and response outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_bus_req    <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_we     <= 1'b0;
            r_bus_be     <= '0;
            r_bus_wdata  <= '0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
            r_inst_ack   <= 1'b0;
            r_data_ack   <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            // ack and error are single-cycle pulses
            r_inst_ack <= 1'b0;
            r_data_ack <= 1'b0;
            r_bus_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // data wins: it belongs to the older instruction
                    if (data_req) begin
                        r_bus_addr  <= word_align(data_paddr);
                        r_bus_we    <= data_we;
                        r_bus_be    <= data_be;
                        r_bus_wdata <= data_wdata;
                        r_bus_req   <= 1'b1;
                        r_state     <= ST_BUS_DATA;
                    end else if (inst_req) begin
                        r_bus_addr  <= word_align(inst_paddr);
                        r_bus_we    <= 1'b0;
                        r_bus_be    <= BE_FULL;
                        r_bus_req   <= 1'b1;
                        r_state     <= ST_BUS_INST;
                    end
                end
                ST_BUS_DATA: begin
                    // an ack in the expiry cycle still counts as success
                    if (bus_ack) begin
                        r_data_rdata <= bus_rdata;
                        r_data_ack   <= 1'b1;
                        r_bus_req    <= 1'b0;
                        r_state      <= ST_RESP;
                    end else if (w_expire) begin
                        r_data_rdata <= '0;
                        r_data_ack   <= 1'b1;
                        r_bus_err    <= 1'b1;
                        r_bus_req    <= 1'b0;
                        r_state      <= ST_RESP;
                    end
                end
                ST_BUS_INST: begin
                    // a fetch already on the bus finishes even if data_req rises
                    if (bus_ack) begin
                        r_inst_rdata <= bus_rdata;
                        r_inst_ack   <= 1'b1;
                        r_bus_req    <= 1'b0;
                        r_state      <= ST_RESP;
                    end else if (w_expire) begin
                        r_inst_rdata <= '0;
                        r_inst_ack   <= 1'b1;
                        r_bus_err    <= 1'b1;
                        r_bus_req    <= 1'b0;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // requester still shows req this cycle, so never issue here
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pipeline stall while a request is up and its ack has not arrived
    assign stall = (inst_req & ~r_inst_ack) | (data_req & ~r_data_ack);

    assign bus_req     = r_bus_req;
    assign bus_addr    = r_bus_addr;
    assign bus_we      = r_bus_we;
    assign bus_be      = r_bus_be;
    assign bus_wdata   = r_bus_wdata;
    assign inst_rdata  = r_inst_rdata;
    assign inst_ack    = r_inst_ack;
    assign data_rdata  = r_data_rdata;
    assign data_ack    = r_data_ack;
    assign bus_err     = r_bus_err;
    assign o_dbg_state = r_state;

    // The two ports never complete together, and an error always rides on an ack
    a_ack_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_inst_ack && r_data_ack));
    a_err_with_ack: assert property (@(posedge clk) disable iff (!rst_n)
        r_bus_err |-> (r_inst_ack || r_data_ack));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter. A transaction-level model tracks each bus job
// by the cycle it starts and the cycle it completes; every cycle the DUT
// outputs are compared against what that schedule implies.
module tb_mem_bus_arbiter;

    localparam int TMO = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        inst_req = 1'b0;
    logic [31:0] inst_paddr = '0;
    logic [31:0] inst_rdata;
    logic        inst_ack;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [3:0]  data_be = '0;
    logic [31:0] data_paddr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        data_ack;
    logic        bus_err;
    logic        stall;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic [1:0]  o_dbg_state;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_req    (inst_req),
        .inst_paddr  (inst_paddr),
        .inst_rdata  (inst_rdata),
        .inst_ack    (inst_ack),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_be     (data_be),
        .data_paddr  (data_paddr),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .data_ack    (data_ack),
        .bus_err     (bus_err),
        .stall       (stall),
        .bus_req     (bus_req),
        .bus_addr    (bus_addr),
        .bus_we      (bus_we),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .bus_ack     (bus_ack),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // requester model: pending requests and their fields
    bit          p_data, p_inst;
    logic [31:0] d_paddr, d_wdata, i_paddr;
    logic        d_we;
    logic [3:0]  d_be;

    // current bus job: start cycle, ack cycle, completion (ack pulse) cycle
    bit          job_act, job_data, job_err;
    int          job_start, job_ackc, job_end;
    logic [31:0] job_rdata;

    // expected register contents
    logic [31:0] exp_addr, exp_wdata, exp_inst_rdata, exp_data_rdata;
    logic        exp_we;
    logic [3:0]  exp_be;

    // scoreboard: {is_data, rdata} per issued job, in completion order
    logic [32:0] exp_q[$];
    // scripted bus delays / read data for directed tests
    int          dly_q[$];
    logic [31:0] rd_q[$];

    bit rand_mode;
    int stray_mode;   // 0 none, 1 random, 2 always-on bus_ack outside bus cycles

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        p_data = 0; p_inst = 0; job_act = 0; job_err = 0; job_data = 0;
        job_start = 0; job_ackc = -1; job_end = 0;
        exp_inst_rdata = '0; exp_data_rdata = '0;
        exp_q.delete(); dly_q.delete(); rd_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic post_data(input logic [31:0] a, input logic we, input logic [3:0] be,
                             input logic [31:0] wd);
        p_data = 1; d_paddr = a; d_we = we; d_be = be; d_wdata = wd;
    endtask

    task automatic post_inst(input logic [31:0] a);
        p_inst = 1; i_paddr = a;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; inst_req = 0; data_req = 0; bus_ack = 0; bus_rdata = '0;
        rand_mode = 0; stray_mode = 0;
        model_clear();
        repeat (2) @(negedge clk);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_be", bus_be, 0);
        check("rst_bus_we", bus_we, 0);
        check("rst_acks", {inst_ack, data_ack, bus_err}, 0);
        check("rst_rdata", inst_rdata | data_rdata, 0);
        check("rst_state", o_dbg_state, 0);
        check("rst_stall", stall, 0);
        rst_n = 1'b1;
    endtask

    // one cycle: drive inputs, compare against the job schedule, then advance model
    task automatic step();
        logic        e_bus, e_ackc, e_dack, e_iack, e_err, idle;
        int          d;
        logic [32:0] ent;
        @(negedge clk);
        cyc++;
        if (rand_mode) begin
            if (!p_data && $urandom_range(0, 3) == 0)
                post_data($urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom);
            if (!p_inst && $urandom_range(0, 2) == 0)
                post_inst($urandom);
        end
        data_req = p_data; data_paddr = d_paddr; data_we = d_we; data_be = d_be;
        data_wdata = d_wdata; inst_req = p_inst; inst_paddr = i_paddr;

        e_bus  = job_act && cyc >= job_start && cyc < job_end;
        e_ackc = job_act && cyc == job_end;
        e_dack = e_ackc && job_data;
        e_iack = e_ackc && !job_data;
        e_err  = e_ackc && job_err;
        if (e_ackc && exp_q.size() > 0) begin
            ent = exp_q.pop_front();
            if (ent[32]) exp_data_rdata = ent[31:0];
            else         exp_inst_rdata = ent[31:0];
        end

        bus_rdata = $urandom;
        if (e_bus) begin
            bus_ack = !job_err && cyc == job_ackc;
            if (bus_ack) bus_rdata = job_rdata;
        end else if (stray_mode == 2) bus_ack = 1'b1;
        else if (stray_mode == 1)     bus_ack = 1'($urandom_range(0, 1));
        else                          bus_ack = 1'b0;

        #1;
        check("bus_req", bus_req, e_bus);
        check("inst_ack", inst_ack, e_iack);
        check("data_ack", data_ack, e_dack);
        check("bus_err", bus_err, e_err);
        check("stall", stall, (inst_req & ~e_iack) | (data_req & ~e_dack));
        check("inst_rdata", inst_rdata, exp_inst_rdata);
        check("data_rdata", data_rdata, exp_data_rdata);
        if (e_bus) begin
            check("bus_addr", bus_addr, exp_addr);
            check("bus_we", bus_we, exp_we);
            check("bus_be", bus_be, exp_be);
            if (exp_we) check("bus_wdata", bus_wdata, exp_wdata);
        end

        idle = !job_act || cyc > job_end;
        if (idle && (p_data || p_inst)) begin
            job_act = 1; job_data = p_data; job_start = cyc + 1;
            if (dly_q.size() > 0) d = dly_q.pop_front();
            else if (rand_mode)   d = int'($urandom_range(0, TMO + 1));
            else                  d = 0;
            if (d < TMO) begin
                job_err = 0; job_ackc = job_start + d; job_end = job_ackc + 1;
                job_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : $urandom;
            end else begin
                job_err = 1; job_ackc = -1; job_end = job_start + TMO; job_rdata = '0;
            end
            exp_q.push_back({job_data, job_rdata});
            if (p_data) begin
                exp_addr = {d_paddr[31:2], 2'b00}; exp_we = d_we; exp_be = d_be; exp_wdata = d_wdata;
            end else begin
                exp_addr = {i_paddr[31:2], 2'b00}; exp_we = 1'b0; exp_be = 4'hF;
            end
        end
        if (e_dack) p_data = 0;
        if (e_iack) p_inst = 0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_clear();

        // single fetch, bus_ack two cycles after bus_req
        do_reset();
        dly_q.push_back(2); rd_q.push_back(32'h24080001);
        post_inst(32'h1FC00004);
        step();                                      // c0: sampled
        step();                                      // c1: on the bus
        check("t1_bus_req", bus_req, 1);
        check("t1_bus_addr", bus_addr, 32'h1FC00004);
        check("t1_bus_be", bus_be, 4'b1111);
        check("t1_stall_busy", stall, 1);
        steps(3);                                    // c4: ack
        check("t1_inst_ack", inst_ack, 1);
        check("t1_inst_rdata", inst_rdata, 32'h24080001);
        step();                                      // c5
        check("t1_stall_after", stall, 0);
        check("t1_ack_pulse", inst_ack, 0);

        // simultaneous data write and fetch, both acked immediately
        do_reset();
        dly_q.push_back(0); dly_q.push_back(0);
        post_data(32'h00001002, 1'b1, 4'b0100, 32'h00AB0000);
        post_inst(32'h00400000);
        step();                                      // c0
        step();                                      // c1
        check("t2_first_addr", bus_addr, 32'h00001000);
        check("t2_first_we", bus_we, 1);
        check("t2_first_be", bus_be, 4'b0100);
        check("t2_first_wdata", bus_wdata, 32'h00AB0000);
        step();                                      // c2
        check("t2_data_ack", data_ack, 1);
        check("t2_no_inst_ack", inst_ack, 0);
        step();                                      // c3: idle, fetch sampled
        check("t2_gap", bus_req, 0);
        step();                                      // c4
        check("t2_fetch_addr", bus_addr, 32'h00400000);
        check("t2_fetch_req", bus_req, 1);
        step();                                      // c5
        check("t2_inst_ack", inst_ack, 1);

        // data_req rises while a fetch waits on the bus
        do_reset();
        dly_q.push_back(3); dly_q.push_back(0);
        post_inst(32'h00400010);
        step(); step();                              // c0, c1
        post_data(32'h00003000, 1'b0, 4'hF, 32'h0);
        step();                                      // c2
        check("t3_addr_held", bus_addr, 32'h00400010);
        steps(3);                                    // c5
        check("t3_inst_first", inst_ack, 1);
        check("t3_data_later", data_ack, 0);
        steps(2);                                    // c7
        check("t3_data_addr", bus_addr, 32'h00003000);
        check("t3_data_we", bus_we, 0);
        step();                                      // c8
        check("t3_data_ack", data_ack, 1);

        // ack in the final waiting cycle counts as success
        do_reset();
        dly_q.push_back(TMO - 1); rd_q.push_back(32'h600DF00D);
        post_data(32'h00005000, 1'b0, 4'hF, 32'h0);
        steps(6);                                    // c5
        check("t4_edge_ack", data_ack, 1);
        check("t4_edge_err", bus_err, 0);
        check("t4_edge_rdata", data_rdata, 32'h600DF00D);

        // no bus_ack at all: abort after TMO cycles
        dly_q.push_back(TMO);
        post_data(32'h00004008, 1'b1, 4'hF, 32'h55AA55AA);
        steps(5);                                    // c4 of this access
        check("t4_still_waiting", bus_req, 1);
        step();                                      // c5
        check("t4_tmo_req", bus_req, 0);
        check("t4_tmo_ack", data_ack, 1);
        check("t4_tmo_err", bus_err, 1);
        check("t4_tmo_rdata", data_rdata, 32'h0);
        dly_q.push_back(1); rd_q.push_back(32'h0BADBEEF);
        post_inst(32'h00000100);
        steps(4);                                    // ack at c3 of this access
        check("t4_next_ack", inst_ack, 1);
        check("t4_next_err", bus_err, 0);
        check("t4_next_rdata", inst_rdata, 32'h0BADBEEF);

        // reset asserted while a data access waits on the bus
        do_reset();
        dly_q.push_back(3);
        post_data(32'h00002000, 1'b1, 4'hF, 32'hCAFEF00D);
        step(); step();
        check("t5_busy", bus_req, 1);
        #2;
        rst_n = 1'b0; data_req = 0; inst_req = 0; bus_ack = 0;
        model_clear();
        #1;
        check("t5_async_clear", bus_req, 0);
        check("t5_state", o_dbg_state, 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("t5_no_ack", data_ack, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dly_q.push_back(1); rd_q.push_back(32'h13572468);
        post_data(32'h00002004, 1'b0, 4'hF, 32'h0);
        steps(4);                                    // c3
        check("t5_reissue_ack", data_ack, 1);
        check("t5_reissue_rdata", data_rdata, 32'h13572468);

        // stray bus_ack in IDLE and RESP
        do_reset();
        stray_mode = 2;
        steps(4);
        check("t6_idle_state", o_dbg_state, 0);
        check("t6_idle_req", bus_req, 0);
        dly_q.push_back(0); rd_q.push_back(32'h11112222);
        post_inst(32'h00000800);
        steps(3);                                    // c2: ack, bus_ack still high
        check("t6_ack", inst_ack, 1);
        step();                                      // c3
        check("t6_no_extra_ack", inst_ack, 0);
        step();                                      // c4
        check("t6_no_reissue", bus_req, 0);
        stray_mode = 0;

        // randomized traffic
        do_reset();
        rand_mode = 1; stray_mode = 1;
        steps(3000);
        rand_mode = 0; stray_mode = 0;
        inst_req = 0; data_req = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // hard time limit so the run always terminates
    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1);
    end

endmodule
